// File: rtl/gpio_disp_pkg.sv
// rtl/gpio_disp_pkg.sv - shared types and constants for the GPIO display bridge
package gpio_disp_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} disp_state_t;

    localparam int BCD_W = 40;
    localparam int BIN_W = 32;

    // Segment patterns in active-high form, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD nibble to active-high seven-segment pattern
module seg7_decode (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = 7'h3F;
            4'd1:    o_seg = 7'h06;
            4'd2:    o_seg = 7'h5B;
            4'd3:    o_seg = 7'h4F;
            4'd4:    o_seg = 7'h66;
            4'd5:    o_seg = 7'h6D;
            4'd6:    o_seg = 7'h7D;
            4'd7:    o_seg = 7'h07;
            4'd8:    o_seg = 7'h7F;
            4'd9:    o_seg = 7'h6F;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/gpio_display_bridge.sv
// rtl/gpio_display_bridge.sv - switch synchroniser and binary-to-decimal display driver for the CPU GPIO port
module gpio_display_bridge
    import gpio_disp_pkg::*;
#(
    parameter int NDIGITS        = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            cpu_gpio_out,
    input  logic [17:0]            sw,
    output logic [31:0]            cpu_gpio_in,
    output logic [7*NDIGITS-1:0]   hex_o,
    output logic                   busy,
    output logic                   ovf
);

    disp_state_t            r_state;
    logic [17:0]            r_sync1, r_sync2;
    logic [BIN_W-1:0]       r_bin, r_last_val;
    logic [BCD_W-1:0]       r_bcd;
    logic [5:0]             r_cnt;
    logic                   r_pending, r_busy, r_ovf;
    logic [7*NDIGITS-1:0]   r_seg;

    logic [BCD_W-1:0]       w_bcd_adj;
    logic                   w_ovf;
    logic [NDIGITS-1:0]     w_blank;
    logic [7*NDIGITS-1:0]   w_seg_dec;

    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < BCD_W / 4; i++) begin
            w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                           : r_bcd[4*i +: 4];
        end
    end

    always_comb begin
        w_ovf = 1'b0;
        for (int i = 4 * NDIGITS; i < BCD_W; i++) begin
            w_ovf = w_ovf | r_bcd[i];
        end
    end

    // Scan from the top digit down; a zero digit is blanked until the first nonzero one
    always_comb begin
        logic w_seen;
        w_seen  = 1'b0;
        w_blank = '0;
        for (int d = NDIGITS - 1; d >= 0; d--) begin
            if (BLANK_LZ && (d != 0) && !w_seen && (r_bcd[4*d +: 4] == 4'd0)) begin
                w_blank[d] = 1'b1;
            end
            if (r_bcd[4*d +: 4] != 4'd0) begin
                w_seen = 1'b1;
            end
        end
    end

    for (genvar d = 0; d < NDIGITS; d++) begin : g_dec
        seg7_decode u_dec (
            .i_bcd (r_bcd[4*d +: 4]),
            .o_seg (w_seg_dec[7*d +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_bin      <= '0;
            r_last_val <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_pending  <= 1'b1;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_seg      <= {NDIGITS{SEG_BLANK}};
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            case (r_state)
                IDLE: begin
                    if (r_pending || (cpu_gpio_out != r_last_val)) begin
                        r_last_val <= cpu_gpio_out;
                        r_bin      <= cpu_gpio_out;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_pending  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_ovf <= w_ovf;
                    for (int d = 0; d < NDIGITS; d++) begin
                        r_seg[7*d +: 7] <= w_ovf        ? SEG_DASH  :
                                           w_blank[d]   ? SEG_BLANK :
                                                          w_seg_dec[7*d +: 7];
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpu_gpio_in = {14'b0, r_sync2};
    assign hex_o       = SEG_ACTIVE_LOW ? ~r_seg : r_seg;
    assign busy        = r_busy;
    assign ovf         = r_ovf;

endmodule
